// File: rtl/pat_pkg.sv
// Shared constants and types for the pattern-replicator stream checker.
package pat_pkg;

    localparam int unsigned DefPatternWidth = 32;
    localparam int unsigned DefOutputWidth  = 64;
    localparam int unsigned DefCyclesPerRow = 4;
    localparam int unsigned DefRowsPerFrame = 3;

    localparam logic [15:0] LfsrSeed = 16'hACE1;
    localparam logic [15:0] LfsrTaps = 16'hB400;

    typedef enum logic {
        StIdle,
        StInFrame
    } chk_state_e;

    // One step of a right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LfsrTaps : 16'h0000);
    endfunction

endpackage

// File: rtl/pat_axis_if.sv
// AXI-Stream beat channel carrying replicated pattern rows.
interface pat_axis_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used to throttle TREADY.
module lfsr16
    import pat_pkg::*;
#(
    parameter logic [15:0] Seed = LfsrSeed
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= Seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/pat_checker.sv
// Sink for replicated pattern frames: checks lanes, row length, frame shape and
// frame-to-frame sequence, and keeps sticky flags plus frame/error counters.
module pat_checker
    import pat_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DefOutputWidth,
    parameter int unsigned PATTERN_WIDTH   = DefPatternWidth,
    parameter int unsigned CYCLES_PER_ROW  = DefCyclesPerRow,
    parameter int unsigned ROWS_PER_FRAME  = DefRowsPerFrame,
    parameter bit          CHECK_INCREMENT = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    pat_axis_if.slave                axis_in,
    input  logic                     throttle_en,
    input  logic                     clear,
    output logic [31:0]              frame_count,
    output logic [31:0]              error_count,
    output logic                     err_lane,
    output logic                     err_pattern,
    output logic                     err_length,
    output logic                     err_sequence,
    output logic [PATTERN_WIDTH-1:0] last_pattern
);

    localparam int unsigned NumLanes = DATA_WIDTH / PATTERN_WIDTH;
    localparam int unsigned BeatW = (CYCLES_PER_ROW > 1) ? $clog2(CYCLES_PER_ROW) : 1;
    localparam int unsigned RowW  = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(CYCLES_PER_ROW - 1);
    localparam logic [RowW-1:0]  LastRow  = RowW'(ROWS_PER_FRAME - 1);

    logic [15:0] lfsr;
    logic        tready;
    logic        accept;

    lfsr16 #(
        .Seed (LfsrSeed)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .en_i    (1'b1),
        .state_o (lfsr)
    );

    assign tready         = !reset && (!throttle_en || lfsr[0]);
    assign axis_in.tready = tready;
    assign accept         = axis_in.tvalid && tready;

    chk_state_e               state_q, state_d;
    logic                     first_frame_q, first_frame_d;
    logic [PATTERN_WIDTH-1:0] frame_pat_q, frame_pat_d;
    logic [PATTERN_WIDTH-1:0] prev_pat_q, prev_pat_d;
    logic [PATTERN_WIDTH-1:0] last_pat_q, last_pat_d;
    logic [BeatW-1:0]         beat_idx_q, beat_idx_d;
    logic [RowW-1:0]          row_idx_q, row_idx_d;
    logic [31:0]              frame_cnt_q, frame_cnt_d;
    logic [31:0]              err_cnt_q, err_cnt_d;
    logic                     err_lane_q, err_lane_d;
    logic                     err_pat_q, err_pat_d;
    logic                     err_len_q, err_len_d;
    logic                     err_seq_q, err_seq_d;

    logic [PATTERN_WIDTH-1:0] lane0;
    logic                     lane_err, pat_err, len_err, seq_err;
    logic                     beat_last, row_end;

    assign lane0     = axis_in.tdata[PATTERN_WIDTH-1:0];
    assign beat_last = (beat_idx_q == LastBeat);
    assign len_err   = axis_in.tlast ^ beat_last;
    assign row_end   = axis_in.tlast | beat_last;
    assign pat_err   = (state_q == StInFrame) && (lane0 != frame_pat_q);
    assign seq_err   = CHECK_INCREMENT && (state_q == StIdle) && !first_frame_q &&
                       (lane0 != (prev_pat_q + PATTERN_WIDTH'(1)));

    always_comb begin
        lane_err = 1'b0;
        for (int i = 1; i < NumLanes; i++) begin
            if (axis_in.tdata[i*PATTERN_WIDTH +: PATTERN_WIDTH] != lane0) begin
                lane_err = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        first_frame_d = first_frame_q;
        frame_pat_d   = frame_pat_q;
        prev_pat_d    = prev_pat_q;
        last_pat_d    = last_pat_q;
        beat_idx_d    = beat_idx_q;
        row_idx_d     = row_idx_q;
        frame_cnt_d   = frame_cnt_q;
        err_cnt_d     = err_cnt_q;
        err_lane_d    = err_lane_q;
        err_pat_d     = err_pat_q;
        err_len_d     = err_len_q;
        err_seq_d     = err_seq_q;

        // Clear wins over a same-cycle accept; that beat is dropped unchecked.
        if (clear) begin
            state_d       = StIdle;
            first_frame_d = 1'b1;
            frame_pat_d   = '0;
            prev_pat_d    = '0;
            last_pat_d    = '0;
            beat_idx_d    = '0;
            row_idx_d     = '0;
            frame_cnt_d   = '0;
            err_cnt_d     = '0;
            err_lane_d    = 1'b0;
            err_pat_d     = 1'b0;
            err_len_d     = 1'b0;
            err_seq_d     = 1'b0;
        end else if (accept) begin
            if (state_q == StIdle) begin
                frame_pat_d   = lane0;
                last_pat_d    = lane0;
                prev_pat_d    = lane0;
                first_frame_d = 1'b0;
            end

            err_lane_d = err_lane_q | lane_err;
            err_pat_d  = err_pat_q | pat_err;
            err_len_d  = err_len_q | len_err;
            err_seq_d  = err_seq_q | seq_err;
            if ((lane_err || pat_err || len_err || seq_err) && (err_cnt_q != 32'hFFFF_FFFF)) begin
                err_cnt_d = err_cnt_q + 32'd1;
            end

            state_d    = StInFrame;
            beat_idx_d = row_end ? '0 : beat_idx_q + BeatW'(1);
            if (row_end) begin
                if (row_idx_q == LastRow) begin
                    row_idx_d   = '0;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    state_d     = StIdle;
                end else begin
                    row_idx_d = row_idx_q + RowW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            first_frame_q <= 1'b1;
            frame_pat_q   <= '0;
            prev_pat_q    <= '0;
            last_pat_q    <= '0;
            beat_idx_q    <= '0;
            row_idx_q     <= '0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
            err_lane_q    <= 1'b0;
            err_pat_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_seq_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            first_frame_q <= first_frame_d;
            frame_pat_q   <= frame_pat_d;
            prev_pat_q    <= prev_pat_d;
            last_pat_q    <= last_pat_d;
            beat_idx_q    <= beat_idx_d;
            row_idx_q     <= row_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
            err_lane_q    <= err_lane_d;
            err_pat_q     <= err_pat_d;
            err_len_q     <= err_len_d;
            err_seq_q     <= err_seq_d;
        end
    end

    assign frame_count  = frame_cnt_q;
    assign error_count  = err_cnt_q;
    assign err_lane     = err_lane_q;
    assign err_pattern  = err_pat_q;
    assign err_length   = err_len_q;
    assign err_sequence = err_seq_q;
    assign last_pattern = last_pat_q;

endmodule
